imem_sequencer: RTL and testbench

Sequencing controller for the 16 x 8 instruction memory. It owns both memory ports:
- In LOAD it accepts a program byte stream over a valid/ready handshake and writes it from address 0 upward.
- In RUN it drives the PC and fetches one instruction per cycle into a registered output, honouring stall, jump and halt.

It sits between the program loader / testbench and the decode stage.

---
 rtl/imem_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_imem_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_sequencer.sv
// imem_sequencer: owns both ports of the 16 x 8 instruction memory.
// LOAD writes a handshaked byte stream from address 0 upward.
// RUN walks the PC, presenting one registered instruction per cycle with stall/jump/halt.
module imem_sequencer #(
    parameter int unsigned    DW          = 8,
    parameter int unsigned    AW          = 4,
    parameter int unsigned    DEPTH       = 16,
    parameter logic [DW-1:0]  HALT_OPCODE = DW'(8'hFF)
) (
    input  logic          clk,
    input  logic          rst,
    // program loader
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    input  logic          load_last,
    output logic          load_ready,
    // run control
    input  logic          run_start,
    input  logic          stall,
    input  logic          jump,
    input  logic [AW-1:0] jump_addr,
    input  logic          abort,
    // memory ports
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_in_data,
    output logic [AW-1:0] mem_pc,
    input  logic [DW-1:0] mem_out_data,
    // decode side / status
    output logic [DW-1:0] instr_out,
    output logic          instr_valid,
    output logic [AW:0]   prog_len,
    output logic          busy,
    output logic          load_done,
    output logic          run_done
);

    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [LW-1:0]   prog_len_q, prog_len_d;
    logic [DW-1:0]   instr_q, instr_d;
    logic            instr_valid_q, instr_valid_d;
    logic            load_done_q, load_done_d;
    logic            run_done_q, run_done_d;
    logic            accept;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, datapath next values and the write handshake.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        pc_d          = pc_q;
        prog_len_d    = prog_len_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        load_done_d   = 1'b0;
        run_done_d    = 1'b0;
        accept        = 1'b0;

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d    = LOAD;
                    wr_ptr_d   = '0;
                    prog_len_d = '0;
                end else if (run_start) begin
                    pc_d = '0;
                    if (prog_len_q == '0) begin
                        state_d    = HALT;
                        run_done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            LOAD: begin
                if (load_valid) begin
                    accept     = 1'b1;
                    wr_ptr_d   = wr_ptr_q + AW'(1);
                    prog_len_d = prog_len_q + LW'(1);
                    // Memory full ends the load even without load_last.
                    if (load_last || (prog_len_q + LW'(1) == LW'(DEPTH))) begin
                        state_d     = IDLE;
                        load_done_d = 1'b1;
                    end
                end
            end

            RUN: begin
                if (!stall) begin
                    if (mem_out_data == HALT_OPCODE) begin
                        state_d    = HALT;
                        run_done_d = 1'b1;
                    end else begin
                        instr_d       = mem_out_data;
                        instr_valid_d = 1'b1;
                        if (jump) begin
                            if ({1'b0, jump_addr} >= prog_len_q) begin
                                state_d    = HALT;
                                run_done_d = 1'b1;
                            end else begin
                                pc_d = jump_addr;
                            end
                        end else if ({1'b0, pc_q} + LW'(1) == prog_len_q) begin
                            state_d    = HALT;
                            run_done_d = 1'b1;
                        end else begin
                            pc_d = pc_q + AW'(1);
                        end
                    end
                end
            end

            HALT: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort drops back to IDLE silently; an accepted load byte still counts.
        if (abort && (state_q != IDLE)) begin
            state_d       = IDLE;
            pc_d          = pc_q;
            instr_d       = instr_q;
            instr_valid_d = 1'b0;
            load_done_d   = 1'b0;
            run_done_d    = 1'b0;
        end
    end

    // Datapath and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            pc_q          <= '0;
            prog_len_q    <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            load_done_q   <= 1'b0;
            run_done_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            pc_q          <= pc_d;
            prog_len_q    <= prog_len_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            load_done_q   <= load_done_d;
            run_done_q    <= run_done_d;
        end
    end

    // Memory ports: write is qualified by the live handshake, read follows the PC.
    assign load_ready  = (state_q == LOAD);
    assign mem_we      = accept;
    assign mem_addr    = wr_ptr_q;
    assign mem_in_data = load_data;
    assign mem_pc      = pc_q;

    assign instr_out   = instr_q;
    assign instr_valid = instr_valid_q;
    assign prog_len    = prog_len_q;
    assign busy        = (state_q != IDLE);
    assign load_done   = load_done_q;
    assign run_done    = run_done_q;

endmodule

// File: tb/tb_imem_sequencer.sv
// Testbench for imem_sequencer: directed cases plus randomized load/run rounds
// checked against a program-level reference model of the fetch sequence.
module tb_imem_sequencer;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned MAXF  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start, load_valid, load_last, load_ready;
    logic [DW-1:0] load_data;
    logic          run_start, stall, jump, abort;
    logic [AW-1:0] jump_addr;
    logic          mem_we;
    logic [AW-1:0] mem_addr, mem_pc;
    logic [DW-1:0] mem_in_data, mem_out_data;
    logic [DW-1:0] instr_out;
    logic          instr_valid, busy, load_done, run_done;
    logic [AW:0]   prog_len;

    imem_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .run_start    (run_start),
        .stall        (stall),
        .jump         (jump),
        .jump_addr    (jump_addr),
        .abort        (abort),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_in_data  (mem_in_data),
        .mem_pc       (mem_pc),
        .mem_out_data (mem_out_data),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .prog_len     (prog_len),
        .busy         (busy),
        .load_done    (load_done),
        .run_done     (run_done)
    );

    always #5 clk = ~clk;

    // Environment memory: synchronous write, combinational read.
    logic [DW-1:0] mem_arr [DEPTH];
    assign mem_out_data = mem_arr[mem_pc];
    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_addr] <= mem_in_data;
    end

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state
    logic [DW-1:0] prog    [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    int            ref_len;
    logic [DW-1:0] exp_instr;
    bit            hold_known;

    // Run plan, indexed by fetch number
    bit            jmp_en  [MAXF];
    logic [AW-1:0] jmp_tgt [MAXF];
    int            stall_n [MAXF];

    // Model output: byte fetched and whether it is presented
    logic [DW-1:0] f_byte [MAXF];
    bit            f_emit [MAXF];
    int            m_nf;

    bit in_load = 1'b0;

    // Any write outside a loading window is an error.
    always @(negedge clk) begin
        if (!rst && mem_we && !in_load) chk("stray_we", 32'(mem_we), 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Program-level walk: fetch, stop on halt byte, jump or step, stop at end.
    function automatic void model_run();
        int pc;
        int k;
        logic [DW-1:0] b;
        m_nf = 0;
        pc   = 0;
        while (ref_len > 0 && m_nf < int'(MAXF)) begin
            b = ref_mem[pc];
            k = m_nf;
            f_byte[k] = b;
            f_emit[k] = (b != 8'hFF);
            m_nf++;
            if (b == 8'hFF) break;
            if (jmp_en[k]) begin
                if (int'(jmp_tgt[k]) >= ref_len) break;
                pc = int'(jmp_tgt[k]);
            end else begin
                if (pc + 1 == ref_len) break;
                pc = pc + 1;
            end
        end
    endfunction

    function automatic void clear_plan();
        for (int k = 0; k < int'(MAXF); k++) begin
            jmp_en[k]  = 1'b0;
            jmp_tgt[k] = '0;
            stall_n[k] = 0;
        end
    endfunction

    // Starts and ends at a falling edge.
    task automatic do_load(input int n, input bit use_last, input bit gaps, input bit both);
        int g;
        load_start = 1'b1;
        run_start  = both;
        in_load    = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        run_start  = 1'b0;
        chk("load_ready_entry", 32'(load_ready), 1);
        chk("load_busy", 32'(busy), 1);
        for (int i = 0; i < n; i++) begin
            g = (gaps && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            for (int j = 0; j < g; j++) begin
                load_valid = 1'b0;
                #1;
                chk("gap_we", 32'(mem_we), 0);
                @(negedge clk);
                chk("gap_ready", 32'(load_ready), 1);
            end
            load_valid = 1'b1;
            load_data  = prog[i];
            load_last  = use_last && (i == n - 1);
            #1;
            chk("wr_we", 32'(mem_we), 1);
            chk("wr_addr", 32'(mem_addr), 32'(i));
            chk("wr_data", 32'(mem_in_data), 32'(prog[i]));
            ref_mem[i] = prog[i];
            @(negedge clk);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        in_load    = 1'b0;
        ref_len    = n;
        chk("load_done", 32'(load_done), 1);
        chk("load_busy_end", 32'(busy), 0);
        chk("load_ready_end", 32'(load_ready), 0);
        chk("prog_len", 32'(prog_len), 32'(n));
        @(negedge clk);
        chk("load_done_pulse", 32'(load_done), 0);
    endtask

    // Starts and ends at a falling edge. abort_at < 0 means run to completion.
    task automatic do_run(input int abort_at);
        model_run();
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        for (int k = 0; k < m_nf; k++) begin
            if (k == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_busy", 32'(busy), 0);
                chk("abort_no_done", 32'(run_done), 0);
                @(negedge clk);
                chk("abort_no_done2", 32'(run_done), 0);
                hold_known = 1'b0;
                return;
            end
            chk("run_busy", 32'(busy), 1);
            for (int s = 0; s < stall_n[k]; s++) begin
                stall      = 1'b1;
                jump       = 1'($urandom_range(0, 1));
                jump_addr  = AW'($urandom_range(0, 15));
                load_start = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("stall_valid", 32'(instr_valid), 0);
                if (hold_known) chk("stall_hold", 32'(instr_out), 32'(exp_instr));
            end
            stall      = 1'b0;
            load_start = 1'b0;
            jump       = jmp_en[k];
            jump_addr  = jmp_tgt[k];
            @(negedge clk);
            jump = 1'b0;
            chk("fetch_valid", 32'(instr_valid), 32'(f_emit[k]));
            if (f_emit[k]) begin
                exp_instr  = f_byte[k];
                hold_known = 1'b1;
            end
            if (hold_known) chk("fetch_instr", 32'(instr_out), 32'(exp_instr));
            if (k < m_nf - 1) chk("early_done", 32'(run_done), 0);
        end
        chk("run_done", 32'(run_done), 1);
        chk("halt_busy", 32'(busy), 1);
        @(negedge clk);
        chk("run_done_pulse", 32'(run_done), 0);
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        rst = 1'b1;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        run_start = 1'b0; stall = 1'b0; jump = 1'b0; jump_addr = '0; abort = 1'b0;
        exp_instr = '0; hold_known = 1'b1; ref_len = 0;
        clear_plan();
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(load_ready), 0);
        chk("rst_len", 32'(prog_len), 0);
        chk("rst_instr", 32'(instr_out), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_ldone", 32'(load_done), 0);
        chk("rst_rdone", 32'(run_done), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_pc", 32'(mem_pc), 0);
        rst = 1'b0;

        // Full 16-byte load without load_last.
        for (int i = 0; i < 16; i++) prog[i] = DW'(i);
        do_load(16, 1'b0, 1'b0, 1'b0);

        // Three-byte program, straight run.
        prog[0] = 8'h11; prog[1] = 8'h22; prog[2] = 8'h33;
        do_load(3, 1'b1, 1'b0, 1'b0);
        clear_plan();
        do_run(-1);

        // Halt opcode stops the run before its byte is presented.
        prog[0] = 8'h01; prog[1] = 8'h02; prog[2] = 8'hFF; prog[3] = 8'h04;
        do_load(4, 1'b1, 1'b0, 1'b0);
        do_run(-1);

        // Length 8: stall after the 2nd fetch, jump to 6 while fetching address 3.
        for (int i = 0; i < 8; i++) prog[i] = DW'(8'hA0 + i);
        do_load(8, 1'b1, 1'b0, 1'b0);
        clear_plan();
        stall_n[2] = 3;
        jmp_en[3]  = 1'b1;
        jmp_tgt[3] = 4'd6;
        do_run(-1);

        // Jump beyond the program halts after the current byte.
        for (int i = 0; i < 5; i++) prog[i] = DW'(8'h30 + i);
        do_load(5, 1'b1, 1'b0, 1'b0);
        clear_plan();
        jmp_en[2]  = 1'b1;
        jmp_tgt[2] = 4'd9;
        do_run(-1);

        // Abort mid-run.
        for (int i = 0; i < 8; i++) prog[i] = DW'(8'h60 + i);
        do_load(8, 1'b1, 1'b0, 1'b0);
        clear_plan();
        do_run(3);

        // Simultaneous load_start/run_start takes LOAD.
        for (int i = 0; i < 4; i++) prog[i] = DW'(8'h70 + i);
        do_load(4, 1'b1, 1'b0, 1'b1);
        clear_plan();
        do_run(-1);

        // Abort mid-load keeps accepted count, no done pulse; abort in IDLE is inert.
        load_start = 1'b1;
        in_load    = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = DW'(8'h40 + i);
            ref_mem[i] = DW'(8'h40 + i);
            @(negedge clk);
        end
        load_valid = 1'b0;
        abort      = 1'b1;
        @(negedge clk);
        abort   = 1'b0;
        in_load = 1'b0;
        ref_len = 3;
        chk("ld_abort_busy", 32'(busy), 0);
        chk("ld_abort_done", 32'(load_done), 0);
        chk("ld_abort_len", 32'(prog_len), 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_busy", 32'(busy), 0);
        chk("idle_abort_len", 32'(prog_len), 3);
        clear_plan();
        do_run(-1);

        // Reset mid-load after 5 bytes.
        load_start = 1'b1;
        in_load    = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            load_valid = 1'b1;
            load_data  = DW'(8'h50 + i);
            ref_mem[i] = DW'(8'h50 + i);
            @(negedge clk);
        end
        load_valid = 1'b1;
        load_data  = 8'h99;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(load_ready), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_len", 32'(prog_len), 0);
        chk("mid_rst_we", 32'(mem_we), 0);
        @(negedge clk);
        rst        = 1'b0;
        load_valid = 1'b0;
        in_load    = 1'b0;
        ref_len    = 0;
        exp_instr  = '0;
        hold_known = 1'b1;

        // Run with an empty program goes straight to HALT.
        clear_plan();
        do_run(-1);

        // Randomized rounds.
        for (int r = 0; r < 24; r++) begin
            int  n;
            bit  ul;
            n  = int'($urandom_range(1, 16));
            ul = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++)
                prog[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : DW'($urandom_range(0, 254));
            do_load(n, ul, 1'b1, 1'b0);
            for (int k = 0; k < int'(MAXF); k++) begin
                jmp_en[k]  = (k < 4) && ($urandom_range(0, 3) == 0);
                jmp_tgt[k] = AW'($urandom_range(0, 15));
                stall_n[k] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            do_run(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
